// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with req/ack memory port and a skid buffer.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int          PC_W    = 20,
  parameter int          INSTR_W = 20,
  parameter int unsigned PC_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    next,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes
`endif
);

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [1:0]         state_q, state_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;

  logic               req_c;
  logic [PC_W-1:0]    addr_c;
  logic [PC_W-1:0]    next_c;
  logic [PC_W-1:0]    pc_inc;
  logic               out_free;
  logic               consume;

  assign pc_inc   = pc + STEP;
  assign out_free = !if_valid_q || id_ready;
  assign consume  = if_valid_q && id_ready;

  // Next-state, next-PC and memory request decode
  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q && !id_ready;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    addr_d       = addr_q;
    req_c        = 1'b0;
    addr_c       = pc;
    next_c       = pc;
    unique case (state_q)
      S_ISSUE: begin
        req_c  = 1'b1;
        addr_c = pc;
        addr_d = pc;
        if (redirect_valid) begin
          // a same-cycle ack completes the old access, so no drain needed
          if_valid_d = 1'b0;
          next_c     = redirect_target;
          state_d    = imem_ack ? S_ISSUE : S_DROP;
        end else if (imem_ack && out_free) begin
          if_valid_d = 1'b1;
          if_instr_d = imem_rdata;
          if_pc_d    = pc;
          next_c     = pc_inc;
        end else if (imem_ack) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc;
          next_c       = pc_inc;
          state_d      = S_STALL;
        end
      end
      S_STALL: begin
        if (redirect_valid) begin
          if_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          next_c       = redirect_target;
          state_d      = S_ISSUE;
        end else if (consume) begin
          if_valid_d   = skid_valid_q;
          if_instr_d   = skid_instr_q;
          if_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_DROP: begin
        // keep the stale request stable until memory answers it
        req_c      = 1'b1;
        addr_c     = addr_q;
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          next_c = redirect_target;
        end
        if (imem_ack) begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        if_valid_d   = 1'b0;
        skid_valid_d = 1'b0;
        state_d      = S_ISSUE;
      end
    endcase
  end

  // Pipeline state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      addr_q       <= addr_d;
    end
  end

  assign imem_req  = req_c && !rst;
  assign imem_addr = addr_c;
  assign next      = rst ? '0 : next_c;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushes_q, flushes_d;

  // Saturating delivery and redirect counters
  always_comb begin
    fetched_d = fetched_q;
    flushes_d = flushes_q;
    if (consume && fetched_q != 32'hFFFF_FFFF) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (redirect_valid && flushes_q != 32'hFFFF_FFFF) begin
      flushes_d = flushes_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushes_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of delivered instructions.
// Models the PC register and a wait-state instruction memory.
module tb_fetch_unit;

  typedef struct packed {
    logic [19:0] pc;
    logic [19:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] pc;
  logic [19:0] next;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ack;
  logic [19:0] imem_rdata;
  logic        redirect_valid;
  logic [19:0] redirect_target;
  logic        if_valid;
  logic [19:0] if_instr;
  logic [19:0] if_pc;
  logic        id_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic       mem_en;
  int         wait_n;
  int         mem_cnt;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .next            (next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .id_ready        (id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_flushes    (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // PC register: loads next every cycle
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= next;
  end

  // Memory: ack after wait_n cycles of a held request
  always @(posedge clk or posedge rst) begin
    if (rst)                       mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else                           mem_cnt <= 0;
  end

  assign imem_ack   = imem_req && mem_en && (mem_cnt >= wait_n);
  assign imem_rdata = imem_addr ^ 20'hA5A5A;

  // Monitor: every consumed instruction must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL deliver_unexpected pc=%h instr=%h", if_pc, if_instr);
      end else begin
        mon_e = sb.pop_front();
        if (if_pc !== mon_e.pc || if_instr !== mon_e.instr) begin
          failures = failures + 1;
          $display("FAIL deliver got pc=%h instr=%h want pc=%h instr=%h",
                   if_pc, if_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic push_range(input logic [19:0] a, input int n);
    logic [19:0] p;
    for (int i = 0; i < n; i++) begin
      p = a + 20'(i);
      sb.push_back({p, p ^ 20'hA5A5A});
    end
  endtask

  task automatic wait_pc(input logic [19:0] t, input int budget,
                         input string nm);
    int k;
    bit hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < budget) begin
      @(posedge clk);
      #1;
      if (pc == t) hit = 1'b1;
      k++;
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    id_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    mem_en          = 1'b1;
    wait_n          = 0;

    @(negedge clk);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_next", 32'(next), 32'd0);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    chk("rst_if_instr", 32'(if_instr), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_flushes", perf_flushes, 32'd0);
`endif

    push_range(20'h0, 32);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    chk("first_next", 32'(next), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stream_next", 32'(next), 32'(pc) + 32'd1);
      chk("stream_if_pc", 32'(if_pc), 32'(pc) - 32'd1);
    end

    // backpressure into the skid buffer
    wait_pc(20'h5, 20, "reach_pc5");
    id_ready = 1'b0;
    @(negedge clk);
    chk("bp_next", 32'(next), 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_next", 32'(next), 32'd6);
      chk("stall_if_pc", 32'(if_pc), 32'd4);
      chk("stall_valid", 32'(if_valid), 32'd1);
    end
    @(posedge clk);
    #1 id_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("skid_if_pc", 32'(if_pc), 32'd5);
    chk("resume_addr", 32'(imem_addr), 32'd6);
    chk("resume_req", 32'(imem_req), 32'd1);

    // wait-state memory at 0x10
    wait_pc(20'h10, 30, "reach_pc10");
    wait_n = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws_req", 32'(imem_req), 32'd1);
      chk("ws_addr", 32'(imem_addr), 32'h10);
      chk("ws_next", 32'(next), 32'h10);
      chk("ws_ack", 32'(imem_ack), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("ws_ack_now", 32'(imem_ack), 32'd1);
    wait_n = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ws_valid", 32'(if_valid), 32'd1);
    chk("ws_if_pc", 32'(if_pc), 32'h10);

    // redirect with an outstanding request
    wait_pc(20'h20, 30, "reach_pc20");
    mem_en          = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 20'h80;
    push_range(20'h80, 4);
    @(negedge clk);
    chk("rd_next", 32'(next), 32'h80);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drop_addr", 32'(imem_addr), 32'h20);
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_valid", 32'(if_valid), 32'd0);
      chk("drop_next", 32'(next), 32'h80);
      @(posedge clk);
      #1;
    end
    mem_en = 1'b1;
    @(negedge clk);
    chk("drop_ack", 32'(imem_ack), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_drop_addr", 32'(imem_addr), 32'h80);
    chk("post_drop_valid", 32'(if_valid), 32'd0);

    // redirect coinciding with ack, target at the top of the space
    wait_pc(20'h84, 20, "reach_pc84");
    redirect_valid  = 1'b1;
    redirect_target = 20'hFFFFF;
    push_range(20'hFFFFF, 3);
    @(negedge clk);
    chk("rda_ack", 32'(imem_ack), 32'd1);
    chk("rda_next", 32'(next), 32'hFFFFF);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr", 32'(imem_addr), 32'hFFFFF);
    chk("wrap_valid", 32'(if_valid), 32'd0);
    chk("wrap_next", 32'(next), 32'd0);

    // asynchronous reset while stalled
    wait_pc(20'h3, 20, "reach_pc3");
    id_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(imem_req), 32'd0);
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_39", perf_fetched, 32'd39);
    chk("perf_flushes_2", perf_flushes, 32'd2);
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_next", 32'(next), 32'd0);
`ifdef FETCH_PERF_EN
    chk("arst_perf_fetched", perf_fetched, 32'd0);
    chk("arst_perf_flushes", perf_flushes, 32'd0);
`endif
    push_range(20'h0, 5);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    wait_pc(20'h6, 20, "reach_pc6");
    id_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("end_if_pc", 32'(if_pc), 32'd5);
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_EN
    chk("end_perf_fetched", perf_fetched, 32'd5);
    chk("end_perf_flushes", perf_flushes, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
